// File: rtl/des_key_schedule.sv
// DES key-schedule generator: takes one post-PC1 key and streams the pre-PC2
// round keys, one per handshake, in encryption or decryption order.
module des_key_schedule #(
    parameter int                HALF_W      = 28,
    parameter int                ROUNDS      = 16,
    parameter logic [ROUNDS-1:0] SHIFT_SCHED = 16'h7EFC,
    parameter int                IDX_W       = $clog2(ROUNDS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_key_load,
    input  logic [2*HALF_W-1:0]   i_key,
    input  logic                  i_mode,
    output logic                  o_load_ready,
    output logic                  o_rk_valid,
    input  logic                  i_rk_ready,
    output logic [2*HALF_W-1:0]   o_rk,
    output logic [IDX_W-1:0]      o_rk_idx,
    output logic                  o_rk_last,
    output logic                  o_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [2*HALF_W-1:0] rk, rk_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic                last, last_next;
    logic                mode, mode_next;
    logic                enc_two, dec_two;

    // Each half rotates on its own; the flag selects a 2-bit instead of a 1-bit step.
    function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] v,
                                                    input logic two);
        return two ? {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]}
                   : {v[HALF_W-2:0], v[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] v,
                                                    input logic two);
        return two ? {v[1:0], v[HALF_W-1:2]}
                   : {v[0], v[HALF_W-1:1]};
    endfunction

    function automatic logic [2*HALF_W-1:0] rot_key(input logic [2*HALF_W-1:0] k,
                                                    input logic two,
                                                    input logic right);
        logic [HALF_W-1:0] c_half;
        logic [HALF_W-1:0] d_half;
        c_half = k[2*HALF_W-1:HALF_W];
        d_half = k[HALF_W-1:0];
        if (right)
            return {rotr_half(c_half, two), rotr_half(d_half, two)};
        else
            return {rotl_half(c_half, two), rotl_half(d_half, two)};
    endfunction

    // Schedule bit for the next round: forward walks s_(idx+2), reverse walks s_(ROUNDS-idx).
    always_comb begin
        enc_two = 1'b0;
        dec_two = 1'b0;
        for (int r = 0; r < ROUNDS; r++) begin
            if (r == int'(idx) + 1)
                enc_two = SHIFT_SCHED[r];
            if (r == ROUNDS - 1 - int'(idx))
                dec_two = SHIFT_SCHED[r];
        end
    end

    always_comb begin
        state_next = state;
        rk_next    = rk;
        idx_next   = idx;
        last_next  = last;
        mode_next  = mode;
        if (i_flush) begin
            state_next = IDLE;
            last_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_key_load) begin
                        mode_next  = i_mode;
                        rk_next    = i_mode ? i_key : rot_key(i_key, SHIFT_SCHED[0], 1'b0);
                        idx_next   = '0;
                        last_next  = 1'b0;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (i_rk_ready) begin
                        if (last) begin
                            state_next = IDLE;
                            last_next  = 1'b0;
                        end else begin
                            idx_next  = idx + IDX_W'(1);
                            last_next = (int'(idx) + 2 == ROUNDS);
                            rk_next   = mode ? rot_key(rk, dec_two, 1'b1)
                                             : rot_key(rk, enc_two, 1'b0);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            rk    <= '0;
            idx   <= '0;
            last  <= 1'b0;
            mode  <= 1'b0;
        end else begin
            state <= state_next;
            rk    <= rk_next;
            idx   <= idx_next;
            last  <= last_next;
            mode  <= mode_next;
        end
    end

    assign o_load_ready = (state == IDLE);
    assign o_rk_valid   = (state == RUN);
    assign o_busy       = (state == RUN);
    assign o_rk         = rk;
    assign o_rk_idx     = idx;
    assign o_rk_last    = last;

endmodule
